// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, configuration field layout,
// oversampling constants and the data-length decode used by rx_module and tx_module.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_t;

    localparam int CONF_PARITY_IDX = 0;
    localparam int CONF_STOP_LSB   = 1;
    localparam int CONF_STOP_W     = 2;
    localparam int CONF_DATA_LSB   = 3;
    localparam int CONF_DATA_W     = 2;
    localparam int CONF_W          = CONF_STOP_W + CONF_DATA_W + 1;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    // 00..11 selects 5..8 data bits
    function automatic logic [3:0] data_bits(input logic [CONF_DATA_W-1:0] data_conf);
        return 4'd5 + {2'b00, data_conf};
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line, with falling-edge detect.
// All flops reset to 1 so an idle-high line never produces a spurious edge.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rx_sync_o,
    output logic fall_o
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rx_i;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rx_sync_o = r_sync;
    assign fall_o    = r_prev & ~r_sync;

endmodule

// File: rtl/rx_module.sv
// UART receive engine: 16x oversampled, 5-8 data bits LSB first, optional even
// parity, 1 or 2 stop bits; registered data/error outputs updated on DONE.
module rx_module
    import uart_pkg::*;
#(
    parameter int MAX_UART_DATA_W = 8,
    parameter int DATA_COUNTER_W  = 3,
    parameter int STOP_CONF_W     = 2,
    parameter int DATA_CONF_W     = 2,
    parameter int SAMPLE_COUNT_W  = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  baud_en_i,
    input  logic                                  rx_en_i,
    input  logic [STOP_CONF_W+DATA_CONF_W:0]      rx_conf_i,
    input  logic                                  uart_rx_i,
    output logic [MAX_UART_DATA_W-1:0]            rx_data_o,
    output logic                                  rx_done_o,
    output logic                                  rx_busy_o,
    output logic                                  parity_err_o,
    output logic                                  frame_err_o
);

    rx_state_t                          r_state;
    rx_state_t                          w_next;
    logic [SAMPLE_COUNT_W-1:0]          r_sample_cnt;
    logic [DATA_COUNTER_W-1:0]          r_bit_idx;
    logic                               r_stop_idx;
    logic [STOP_CONF_W+DATA_CONF_W:0]   r_conf;
    logic [MAX_UART_DATA_W-1:0]         r_data_buf;
    logic                               r_perr_acc;
    logic                               r_ferr_acc;
    logic [MAX_UART_DATA_W-1:0]         r_data;
    logic                               r_done;
    logic                               r_busy;
    logic                               r_perr;
    logic                               r_ferr;

    logic                               w_rx;
    logic                               w_fall;
    logic                               w_mid_tick;
    logic                               w_bit_tick;
    logic                               w_parity_en;
    logic                               w_two_stop;
    logic [DATA_COUNTER_W-1:0]          w_last_idx;
    logic                               w_start_frame;

    uart_rx_sync u_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rx_i      (uart_rx_i),
        .rx_sync_o (w_rx),
        .fall_o    (w_fall)
    );

    assign w_mid_tick    = baud_en_i && (r_sample_cnt == SAMPLE_COUNT_W'(MID_SAMPLE - 1));
    assign w_bit_tick    = baud_en_i && (r_sample_cnt == SAMPLE_COUNT_W'(OVERSAMPLE - 1));
    assign w_parity_en   = r_conf[CONF_PARITY_IDX];
    assign w_two_stop    = |r_conf[CONF_STOP_LSB +: STOP_CONF_W];
    assign w_last_idx    = DATA_COUNTER_W'(data_bits(r_conf[CONF_DATA_LSB +: DATA_CONF_W]) - 4'd1);
    assign w_start_frame = (r_state == IDLE) && (w_next == START);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Dropping rx_en_i aborts any frame in progress on the next clock
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (rx_en_i && w_fall) w_next = START;
                else                   w_next = IDLE;
            end
            START: begin
                if (!rx_en_i)        w_next = IDLE;
                else if (w_mid_tick) w_next = w_rx ? IDLE : DATA;
                else                 w_next = START;
            end
            DATA: begin
                if (!rx_en_i)                                  w_next = IDLE;
                else if (w_bit_tick && (r_bit_idx == w_last_idx)) w_next = w_parity_en ? PARITY : STOP;
                else                                           w_next = DATA;
            end
            PARITY: begin
                if (!rx_en_i)        w_next = IDLE;
                else if (w_bit_tick) w_next = STOP;
                else                 w_next = PARITY;
            end
            STOP: begin
                if (!rx_en_i)                                    w_next = IDLE;
                else if (w_bit_tick && (r_stop_idx || !w_two_stop)) w_next = DONE;
                else                                             w_next = STOP;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sample_cnt <= '0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_conf       <= '0;
            r_data_buf   <= '0;
            r_perr_acc   <= 1'b0;
            r_ferr_acc   <= 1'b0;
        end else begin
            // Counter restarts at START entry and again at the start-bit midpoint
            if ((r_state == IDLE) || (w_next == IDLE) || ((r_state == START) && w_mid_tick)) begin
                r_sample_cnt <= '0;
            end else if (baud_en_i) begin
                r_sample_cnt <= r_sample_cnt + SAMPLE_COUNT_W'(1);
            end

            if (w_start_frame) begin
                r_conf     <= rx_conf_i;
                r_data_buf <= '0;
                r_perr_acc <= 1'b0;
                r_ferr_acc <= 1'b0;
                r_bit_idx  <= '0;
            end else if ((r_state == DATA) && w_bit_tick) begin
                r_data_buf[r_bit_idx] <= w_rx;
                r_bit_idx             <= r_bit_idx + DATA_COUNTER_W'(1);
            end else if ((r_state == PARITY) && w_bit_tick) begin
                r_perr_acc <= (^r_data_buf) ^ w_rx;
            end else if ((r_state == STOP) && w_bit_tick && !w_rx) begin
                r_ferr_acc <= 1'b1;
            end

            if (r_state != STOP)  r_stop_idx <= 1'b0;
            else if (w_bit_tick)  r_stop_idx <= 1'b1;
        end
    end

    // Outputs take their new values in the same edge that enters DONE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_done <= (w_next == DONE);
            r_busy <= (w_next != IDLE);
            if (w_next == DONE) begin
                r_data <= r_data_buf;
                r_perr <= r_perr_acc;
                r_ferr <= r_ferr_acc | ~w_rx;
            end
        end
    end

    assign rx_data_o    = r_data;
    assign rx_done_o    = r_done;
    assign rx_busy_o    = r_busy;
    assign parity_err_o = r_perr;
    assign frame_err_o  = r_ferr;

endmodule

// File: tb/tb_rx_module.sv
// Scoreboard bench for rx_module: directed frames push expectations, a
// negedge monitor pops and compares on every rx_done_o pulse.
module tb_rx_module;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_en = 1'b0;
    logic       rx_en = 1'b0;
    logic [4:0] conf = 5'b00000;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       perr;
    logic       ferr;

    int         checks = 0;
    int         failures = 0;
    int         baud_div = 1;
    int         cyc = 0;
    int         t_start = 0;
    logic [7:0] last_data = 8'h00;
    exp_t       sb_q[$];

    rx_module dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .baud_en_i    (baud_en),
        .rx_en_i      (rx_en),
        .rx_conf_i    (conf),
        .uart_rx_i    (uart_rx),
        .rx_data_o    (rx_data),
        .rx_done_o    (rx_done),
        .rx_busy_o    (rx_busy),
        .parity_err_o (perr),
        .frame_err_o  (ferr)
    );

    always #5 clk = ~clk;

    initial begin
        int dc;
        dc = 0;
        forever begin
            @(negedge clk);
            baud_en = (dc == 0);
            dc = (dc + 1) % baud_div;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse
    initial begin
        exp_t e;
        logic busy_q;
        busy_q = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rx_busy === 1'b1 && busy_q !== 1'b1) t_start = cyc;
            busy_q = rx_busy;
            if (rx_done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 expected=0 data=0x%0h", rx_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("data", {24'd0, rx_data}, {24'd0, e.data});
                    chk("parity_err", {31'd0, perr}, {31'd0, e.perr});
                    chk("frame_err", {31'd0, ferr}, {31'd0, e.ferr});
                    if (e.lat != 0) chk("done_latency", cyc - t_start, e.lat);
                    last_data = e.data;
                end
            end
        end
    end

    task automatic bit_wait();
        repeat (16 * baud_div) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int len, input bit par, input bit flip,
                              input int nstop, input bit stop_low, input bit chg, input logic [4:0] conf_mid);
        exp_t e;
        logic [7:0] m;
        logic       p;
        m      = 8'((1 << len) - 1);
        p      = ^(d & m);
        e.data = d & m;
        e.perr = par & flip;
        e.ferr = stop_low;
        e.lat  = (baud_div == 1) ? 8 + 16 * (len + int'(par) + nstop) : 0;
        sb_q.push_back(e);
        @(negedge clk);
        uart_rx = 1'b0;
        bit_wait();
        if (chg) conf = conf_mid;
        for (int i = 0; i < len; i++) begin
            uart_rx = d[i];
            bit_wait();
        end
        if (par) begin
            uart_rx = p ^ flip;
            bit_wait();
        end
        for (int s = 0; s < nstop; s++) begin
            uart_rx = (s == 0 && stop_low) ? 1'b0 : 1'b1;
            bit_wait();
        end
        uart_rx = 1'b1;
        bit_wait();
        bit_wait();
    endtask

    initial begin
        exp_t e;
        int   bc;
        int   guard;

        repeat (3) @(negedge clk);
        chk("reset_data", {24'd0, rx_data}, 32'd0);
        chk("reset_done", {31'd0, rx_done}, 32'd0);
        chk("reset_busy", {31'd0, rx_busy}, 32'd0);
        chk("reset_perr", {31'd0, perr}, 32'd0);
        chk("reset_ferr", {31'd0, ferr}, 32'd0);
        rst   = 1'b0;
        rx_en = 1'b1;
        repeat (20) @(negedge clk);

        conf = 5'b11000;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0, 5'b00000);

        conf = 5'b10011;
        send_frame(8'h5A, 7, 1'b1, 1'b0, 2, 1'b0, 1'b0, 5'b00000);
        send_frame(8'h5A, 7, 1'b1, 1'b1, 2, 1'b0, 1'b0, 5'b00000);

        conf = 5'b11000;
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 5'b00000);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1, 5'b00011);
        conf = 5'b11000;

        // Short low glitch: START is entered and abandoned at the midpoint
        @(negedge clk);
        uart_rx = 1'b0;
        bc = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 4) uart_rx = 1'b1;
            @(negedge clk);
            if (rx_busy) bc++;
        end
        chk("glitch_busy_cycles", bc, 8);

        // Abort mid-DATA by dropping the enable
        @(negedge clk);
        uart_rx = 1'b0;
        bit_wait();
        uart_rx = 1'b1;
        bit_wait();
        uart_rx = 1'b0;
        bit_wait();
        chk("abort_busy_before", {31'd0, rx_busy}, 32'd1);
        rx_en = 1'b0;
        uart_rx = 1'b1;
        @(negedge clk);
        chk("abort_busy_after", {31'd0, rx_busy}, 32'd0);
        chk("abort_data_held", {24'd0, rx_data}, {24'd0, last_data});
        bit_wait();
        bit_wait();
        rx_en = 1'b1;
        bit_wait();
        send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0, 5'b00000);

        baud_div = 4;
        conf = 5'b00000;
        bit_wait();
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 5'b00000);
        send_frame(8'hE3, 5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 5'b00000);

        // Break: one frame of zeros with framing error, then silence until the line rises
        baud_div = 1;
        conf = 5'b11000;
        bit_wait();
        e.data = 8'h00;
        e.perr = 1'b0;
        e.ferr = 1'b1;
        e.lat  = 152;
        sb_q.push_back(e);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (14) bit_wait();
        uart_rx = 1'b1;
        bit_wait();
        bit_wait();
        send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0, 5'b00000);

        // Asynchronous reset in the middle of a frame
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) bit_wait();
        chk("rst_mid_busy_before", {31'd0, rx_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
        chk("rst_mid_data", {24'd0, rx_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        uart_rx = 1'b1;
        bit_wait();

        guard = 0;
        while (sb_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("scoreboard_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_module.md
Name: rx_module

Overview:
UART receive engine, the counterpart of tx_module. It oversamples the serial line on a shared baud-enable tick (16 ticks per bit) and deserialises one frame of 5-8 data bits, LSB first, with optional even parity and 1 or 2 stop bits. It presents the data word with a one-cycle done pulse plus parity and framing error flags. It sits beside tx_module under the UART top and shares the same baud generator and configuration format.

Parameters:
MAX_UART_DATA_W, 8, maximum data bits; width of rx_data_o
DATA_COUNTER_W, 3, width of the received-bit index counter
STOP_CONF_W, 2, width of the stop-bit configuration field
DATA_CONF_W, 2, width of the data-length configuration field
SAMPLE_COUNT_W, 4, oversample counter width; 2**SAMPLE_COUNT_W ticks per bit

Ports:
clk_i  in  1  system clock; the block's only clock
rst_i  in  1  asynchronous, active-high reset
baud_en_i  in  1  oversample tick; one-cycle strobe, 16 per bit period
rx_en_i  in  1  receiver enable
rx_conf_i  in  STOP_CONF_W+DATA_CONF_W+1  [4:3] data len (00=5, 01=6, 10=7, 11=8); [2:1] stop (00=1 bit, other=2 bits); [0] parity (1=even, 0=none)
uart_rx_i  in  1  serial line; asynchronous; idle high
rx_data_o  out  MAX_UART_DATA_W  received word, zero-extended above the configured length
rx_done_o  out  1  one-cycle pulse when a frame completes
rx_busy_o  out  1  high while in any state other than IDLE
parity_err_o  out  1  parity mismatch on the last frame
frame_err_o  out  1  a stop bit sampled low on the last frame

Behaviour:
- Reset: state IDLE. rx_data_o=0, rx_done_o=0, rx_busy_o=0, parity_err_o=0, frame_err_o=0. All counters are 0 and the synchroniser flops are set to 1.
- uart_rx_i passes through a 2-flop synchroniser. A falling edge is a synced 1 followed by a synced 0.
- All sample counters advance only on cycles where baud_en_i=1. The state register updates on clk_i.
- IDLE:
  - Falling edge with rx_en_i=1 -> START. Latch rx_conf_i and clear the sample counter.
  - Otherwise remain in IDLE.
- START: on the 8th tick (mid-bit), sample the line.
  - Low -> DATA; clear the bit index.
  - High -> IDLE (glitch reject); no done pulse.
- DATA:
  - Every 16 ticks from the mid-point, shift the sampled bit into the shift register, LSB first.
  - After the last configured bit (index = len-1) -> PARITY if parity is enabled, else STOP.
- PARITY: after 16 ticks, sample. The error is set if XOR(data bits, sampled parity bit) != 0 (even parity).
- STOP:
  - Sample every 16 ticks, once or twice depending on the latched stop config.
  - Any low sample sets the frame error.
  - After the final sample -> DONE.
- DONE (one cycle):
  - rx_done_o=1.
  - rx_data_o, parity_err_o and frame_err_o update in this cycle and hold until the next DONE.
  - Next state is IDLE.
  - A new start bit can be detected from the cycle after DONE.
- Latency: rx_done_o rises 1 clk after the tick sampling the final stop bit. That tick is tick number 8 + 16*(len + P + S) counted from the first tick in START, where len is the data length, P the parity bit count (0/1) and S the stop bit count.
- rx_en_i deasserted in any non-IDLE state -> IDLE on the next clk. No done pulse; outputs keep their previous values.
- rx_conf_i changes during a frame have no effect; the latched copy is used.
- baud_en_i stuck at 0 freezes the FSM in its current state. rx_busy_o stays high.
- Asynchronous reset mid-frame: immediate return to the reset values listed above.
- A line held low (break) gives a frame with data=0 and frame_err_o=1. A new frame then requires a high-to-low edge.

Decomposition:
- uart_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, DONE);
  - conf field offsets and widths;
  - the function decoding data-conf to bit count;
  - the OVERSAMPLE and MID_SAMPLE constants.
  tx_module imports the same package.
- Sub-module uart_rx_sync: 2-flop synchroniser with falling-edge detect; reset value 1.

Test Plan:
- 8N1 (conf 5'b11000), baud_en_i=1 every cycle, send 0xA5 -> one rx_done_o pulse; rx_data_o=0xA5; both error flags 0; done at tick 8+16*9=152 after START entry.
- 7E2 (conf 5'b10011), send 0x5A with correct parity 0 -> data=0x5A, parity_err_o=0. Repeat with the parity bit flipped -> parity_err_o=1, data still 0x5A.
- 8N1, stop bit forced low -> frame_err_o=1, data correct. The next clean frame 0x3C clears frame_err_o.
- 4-tick low glitch on the idle line -> return to IDLE, no rx_done_o, rx_busy_o high for about 8 ticks only.
- rx_en_i dropped mid-DATA -> FSM returns to IDLE next cycle with no done pulse and rx_data_o unchanged. Re-enable and send 0x81 -> 0x81.
- 5N1 (conf 5'b00000), send 0x1F with baud_en_i every 4th cycle -> rx_data_o=0x1F, upper bits 0.
